// File: rtl/dram_unpacker.sv
// rtl/dram_unpacker.sv - reads DRAM lines and unpacks them into a sample stream
// One read outstanding at a time; returned lines land in a two-entry buffer drained LSB-slice first.
module dram_unpacker #(
  parameter int SAMPLE_PACKET_WIDTH = 32,
  parameter int MEM_IF_WIDTH        = 128,
  parameter int ADX_WIDTH           = 27,
  parameter int MEMORY_WORD_WIDTH   = 2
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [31:0]                    start_sample,
  input  logic [31:0]                    sample_count,
  output logic                           busy,
  output logic                           done,
  output logic [SAMPLE_PACKET_WIDTH-1:0] sample_data,
  output logic                           sample_valid,
  input  logic                           sample_ready,
  output logic [ADX_WIDTH-1:0]           dram_adx,
  output logic                           read_req,
  input  logic                           read_allowed,
  input  logic [MEM_IF_WIDTH-1:0]        dram_rd_data,
  input  logic                           dram_rd_valid
);

  localparam int PACK_SIZE    = MEM_IF_WIDTH / SAMPLE_PACKET_WIDTH;
  localparam int OFF_W        = $clog2(PACK_SIZE);
  localparam int SAMPLE_WORDS = SAMPLE_PACKET_WIDTH / 8 / MEMORY_WORD_WIDTH;
  localparam int LINE_STEP    = PACK_SIZE * SAMPLE_WORDS;

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_FULL} rstate_t;
  typedef logic [PACK_SIZE-1:0][SAMPLE_PACKET_WIDTH-1:0] line_t;

  rstate_t              rstate_q, rstate_d;
  logic [ADX_WIDTH-1:0] adx_q, adx_d;
  logic [31:0]          lines_left_q, lines_left_d;
  logic [31:0]          remain_q, remain_d;
  logic [OFF_W-1:0]     offset_q, offset_d;
  line_t                buf_q [2];
  line_t                buf_d [2];
  logic                 head_q, head_d;
  logic [1:0]           count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 accept, xfer, last_xfer, pop, push;
  logic [ADX_WIDTH-1:0] first_adx;
  logic [33:0]          span;
  logic [1:0]           count_after;

  assign accept      = start && !busy_q;
  assign sample_valid = (count_q != 2'd0);
  assign xfer        = sample_valid && sample_ready;
  assign last_xfer   = xfer && (remain_q == 32'd1);
  assign pop         = xfer && ((offset_q == OFF_W'(PACK_SIZE - 1)) || (remain_q == 32'd1));
  assign push        = (rstate_q == R_WAIT) && dram_rd_valid;
  assign count_after = count_q + {1'b0, push} - {1'b0, pop};

  // Line-aligned start address; span rounds the line count up to whole lines.
  assign first_adx = ADX_WIDTH'(start_sample * 32'(SAMPLE_WORDS)) & ~ADX_WIDTH'(LINE_STEP - 1);
  assign span      = 34'(start_sample[OFF_W-1:0]) + 34'(sample_count) + 34'(PACK_SIZE - 1);

  assign busy        = busy_q;
  assign done        = done_q;
  assign dram_adx    = adx_q;
  assign read_req    = (rstate_q == R_ISSUE) && read_allowed;
  assign sample_data = buf_q[head_q][offset_q];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rstate_q     <= R_IDLE;
      adx_q        <= '0;
      lines_left_q <= '0;
      remain_q     <= '0;
      offset_q     <= '0;
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
      head_q       <= 1'b0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rstate_q     <= rstate_d;
      adx_q        <= adx_d;
      lines_left_q <= lines_left_d;
      remain_q     <= remain_d;
      offset_q     <= offset_d;
      buf_q[0]     <= buf_d[0];
      buf_q[1]     <= buf_d[1];
      head_q       <= head_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    rstate_d     = rstate_q;
    adx_d        = adx_q;
    lines_left_d = lines_left_q;
    remain_d     = remain_q;
    offset_d     = offset_q;
    buf_d[0]     = buf_q[0];
    buf_d[1]     = buf_q[1];
    head_d       = head_q;
    count_d      = count_after;
    busy_d       = busy_q;
    done_d       = 1'b0;

    if (accept) begin
      if (sample_count == 32'd0) begin
        done_d = 1'b1;
      end else begin
        busy_d       = 1'b1;
        rstate_d     = R_ISSUE;
        adx_d        = first_adx;
        lines_left_d = span[OFF_W +: 32];
        remain_d     = sample_count;
        offset_d     = start_sample[OFF_W-1:0];
        head_d       = 1'b0;
        count_d      = 2'd0;
      end
    end

    case (rstate_q)
      R_ISSUE: if (read_allowed) rstate_d = R_WAIT;
      R_WAIT: begin
        if (dram_rd_valid) begin
          // Tail slot is the entry behind the head when one line is already held.
          buf_d[head_q ^ count_q[0]] = dram_rd_data;
          adx_d        = adx_q + ADX_WIDTH'(LINE_STEP);
          lines_left_d = lines_left_q - 32'd1;
          if (lines_left_q == 32'd1)   rstate_d = R_IDLE;
          else if (count_after == 2'd2) rstate_d = R_FULL;
          else                          rstate_d = R_ISSUE;
        end
      end
      R_FULL:  if (pop) rstate_d = R_ISSUE;
      default: ;
    endcase

    if (xfer) begin
      offset_d = offset_q + OFF_W'(1);
      remain_d = remain_q - 32'd1;
      if (pop) head_d = ~head_q;
      if (last_xfer) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_unpacker.sv
// tb/tb_dram_unpacker.sv - directed and randomized readouts checked against a sample-numbering model
module tb_dram_unpacker;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [31:0]  start_sample;
  logic [31:0]  sample_count;
  logic         busy;
  logic         done;
  logic [31:0]  sample_data;
  logic         sample_valid;
  logic         sample_ready;
  logic [26:0]  dram_adx;
  logic         read_req;
  logic         read_allowed;
  logic [127:0] dram_rd_data;
  logic         dram_rd_valid;

  int checks;
  int errors;
  int issued;
  int returned;
  int mem_lat;
  logic [26:0] adx_log[$];

  dram_unpacker dut (
    .clk(clk), .resetn(resetn), .start(start), .start_sample(start_sample),
    .sample_count(sample_count), .busy(busy), .done(done), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .dram_adx(dram_adx),
    .read_req(read_req), .read_allowed(read_allowed), .dram_rd_data(dram_rd_data),
    .dram_rd_valid(dram_rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: each 32-bit slot is a hash of its line address and slot index.
  function automatic logic [31:0] line_word(input logic [26:0] adx, input int k);
    return (32'({adx, 2'(k)}) * 32'h9E3779B1) ^ 32'hA5C30F1E;
  endfunction

  // Sample n lives in line floor(n/4) (8 address units per line), slot n mod 4.
  function automatic logic [31:0] exp_sample(input logic [31:0] n);
    logic [26:0] line_adx;
    line_adx = 27'((n / 32'd4) * 32'd8);
    return line_word(line_adx, int'(n % 32'd4));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin : mem_model
    int t;
    int due_q[$];
    logic [26:0] pend_q[$];
    t = 0;
    issued = 0;
    returned = 0;
    dram_rd_valid = 1'b0;
    dram_rd_data = '0;
    forever begin
      @(negedge clk);
      if (read_req === 1'b1) begin
        adx_log.push_back(dram_adx);
        pend_q.push_back(dram_adx);
        due_q.push_back(t + mem_lat);
        issued++;
      end
      @(posedge clk); #1;
      t++;
      if (dram_rd_valid) begin
        returned++;
        dram_rd_valid = 1'b0;
      end
      if (due_q.size() > 0 && due_q[0] <= t) begin
        dram_rd_valid = 1'b1;
        for (int k = 0; k < 4; k++) dram_rd_data[k*32 +: 32] = line_word(pend_q[0], k);
        void'(due_q.pop_front());
        void'(pend_q.pop_front());
      end
    end
  end

  task automatic run(input logic [31:0] s, input logic [31:0] c, input int ra_hold,
                     input int rdy_hold, input bit rnd, input bit sb);
    int cn, off, nlines, got, cyc, bi, br, consumed, buffered;
    bit pending_done, prev_valid, prev_ready;
    logic [31:0] prev_data;
    logic [26:0] first_adx;
    logic [31:0] exp_q[$];
    cn = int'(c);
    off = int'(s % 32'd4);
    nlines = (cn == 0) ? 0 : (off + cn + 3) / 4;
    first_adx = 27'((s / 32'd4) * 32'd8);
    for (int i = 0; i < cn; i++) exp_q.push_back(exp_sample(s + 32'(i)));
    bi = issued;
    br = returned;
    got = 0;
    cyc = 0;
    pending_done = (cn == 0);
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data = '0;
    start = 1'b1;
    start_sample = s;
    sample_count = c;
    read_allowed = (ra_hold == 0);
    sample_ready = (rdy_hold == 0);
    @(posedge clk); #1;
    start = 1'b0;
    while ((got < cn || pending_done) && cyc < 3000) begin
      @(negedge clk); #1;
      cyc++;
      consumed = (got == cn) ? nlines : (off + got) / 4;
      buffered = (returned - br) - consumed;
      check("occupancy", 64'(buffered >= 0 && buffered <= 2), 1);
      check("valid", sample_valid, buffered > 0);
      if (pending_done) begin
        check("done", done, 1);
        check("busy_fall", busy, 0);
        pending_done = 1'b0;
      end else begin
        check("done_idle", done, 0);
        check("busy", busy, 1);
      end
      if (read_req) begin
        check("one_outstanding", 64'(issued - returned), 1);
        check("no_read_when_full", 64'(buffered < 2), 1);
      end
      if (ra_hold > 0 && cyc <= ra_hold) begin
        check("hold_read_req", read_req, 0);
        check("hold_adx", dram_adx, first_adx);
      end
      if (ra_hold > 0 && cyc == ra_hold + 1) check("first_allowed_read", read_req, 1);
      if (rdy_hold > 0 && cyc == rdy_hold) check("fill_reads", 64'(issued - bi), nlines < 2 ? nlines : 2);
      if (prev_valid && !prev_ready) begin
        check("stable_valid", sample_valid, 1);
        check("stable_data", sample_data, prev_data);
      end
      if (sample_valid && sample_ready && got < cn) begin
        check("sample", sample_data, exp_q[got]);
        got++;
        if (got == cn) pending_done = 1'b1;
      end
      prev_valid = sample_valid;
      prev_ready = sample_ready;
      prev_data = sample_data;
      @(posedge clk); #1;
      start = sb && (cyc == 2);
      if (start) begin
        start_sample = s + 32'd100;
        sample_count = 32'd3;
      end
      read_allowed = (cyc + 1 > ra_hold) && (!rnd || $urandom_range(0, 3) != 0);
      sample_ready = (cyc + 1 > rdy_hold) && (!rnd || $urandom_range(0, 2) != 0);
    end
    start = 1'b0;
    check("timeout", 64'(got == cn && !pending_done), 1);
    repeat (4) begin
      @(negedge clk); #1;
      check("tail_done", done, 0);
      check("tail_busy", busy, 0);
      check("tail_valid", sample_valid, 0);
      check("tail_read", read_req, 0);
      @(posedge clk); #1;
    end
    check("read_count", 64'(issued - bi), nlines);
    for (int i = 0; i < nlines && bi + i < adx_log.size(); i++)
      check("read_adx", adx_log[bi + i], 27'(first_adx + 27'(8 * i)));
  endtask

  initial begin : main
    logic [31:0] rs, rc;
    checks = 0;
    errors = 0;
    mem_lat = 3;
    resetn = 1'b0;
    start = 1'b0;
    start_sample = '0;
    sample_count = '0;
    sample_ready = 1'b0;
    read_allowed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_read_req", read_req, 0);
    check("rst_adx", dram_adx, 0);
    check("rst_data", sample_data, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run(32'd0, 32'd4, 0, 0, 1'b0, 1'b0);
    run(32'd6, 32'd5, 0, 0, 1'b0, 1'b0);
    run(32'd1, 32'd12, 0, 20, 1'b0, 1'b0);
    run(32'd9, 32'd3, 10, 0, 1'b0, 1'b0);
    run(32'd5, 32'd0, 0, 0, 1'b0, 1'b0);
    run(32'd2, 32'd7, 0, 0, 1'b0, 1'b1);
    run(32'h0400_0000 - 32'd2, 32'd6, 0, 0, 1'b0, 1'b0);

    // Abort while a read is outstanding; its late data must be dropped.
    mem_lat = 6;
    start = 1'b1;
    start_sample = 32'd3;
    sample_count = 32'd6;
    read_allowed = 1'b1;
    sample_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("abort_valid", sample_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_read", read_req, 0);
    end
    @(posedge clk); #1;
    mem_lat = 3;
    run(32'd3, 32'd6, 0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      mem_lat = int'($urandom_range(1, 5));
      rs = ($urandom_range(0, 4) == 0) ? 32'h0400_0000 - $urandom_range(1, 8) : $urandom_range(0, 40);
      rc = $urandom_range(0, 20);
      run(rs, rc, 0, 0, 1'b1, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_unpacker.md
DRAM_UNPACKER -- requirements
Module: dram_unpacker

Interface
REQ-001 SHALL have parameter SAMPLE_PACKET_WIDTH, default 32, sample width in bits.
REQ-002 SHALL have parameter MEM_IF_WIDTH, default 128, memory interface data width.
REQ-003 SHALL have parameter ADX_WIDTH, default 27, memory address width.
REQ-004 SHALL have parameter MEMORY_WORD_WIDTH, default 2, bytes per memory address unit.
REQ-005 SHALL have port clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-006 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a readout.
REQ-008 SHALL have port start_sample  input  32  first sample number to read.
REQ-009 SHALL have port sample_count  input  32  number of samples to emit.
REQ-010 SHALL have port busy  output  1  readout in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at readout completion.
REQ-012 SHALL have port sample_data  output  SAMPLE_PACKET_WIDTH  sample to consumer.
REQ-013 SHALL have port sample_valid  output  1  sample_data valid.
REQ-014 SHALL have port sample_ready  input  1  consumer accepts sample.
REQ-015 SHALL have port dram_adx  output  ADX_WIDTH  read address to memory interface.
REQ-016 SHALL have port read_req  output  1  read command to memory interface.
REQ-017 SHALL have port read_allowed  input  1  memory interface accepts a read command this cycle.
REQ-018 SHALL have port dram_rd_data  input  MEM_IF_WIDTH  returned read line.
REQ-019 SHALL have port dram_rd_valid  input  1  dram_rd_data valid.

Function
REQ-020 SHALL define PACK_SIZE = MEM_IF_WIDTH/SAMPLE_PACKET_WIDTH (4), samples per line; sample k of a line SHALL occupy bits [k*32+31:k*32], with k=0 at the LSBs.
REQ-021 SHALL compute the first line address as (start_sample*(SAMPLE_PACKET_WIDTH/8/MEMORY_WORD_WIDTH)) with bits [2:0] forced to 0; start_sample=5 -> 8. The first-line offset is start_sample mod PACK_SIZE.
REQ-022 SHALL accept start only when busy=0; start while busy=1 is ignored. Inputs are captured on acceptance, and busy=1 from the next cycle.
REQ-023 SHALL, for sample_count=0, issue no reads and pulse done the cycle after start, with busy staying 0.
REQ-024 SHALL fetch exactly ceil((offset+sample_count)/PACK_SIZE) lines, each address +8 over the previous, wrapping modulo 2^ADX_WIDTH.
REQ-025 SHALL run a read FSM with states R_IDLE, R_ISSUE, R_WAIT, R_FULL, and SHALL allow at most one outstanding read.
REQ-026 R_IDLE -> R_ISSUE on an accepted start with sample_count>0.
REQ-027 In R_ISSUE, read_req SHALL equal read_allowed, combinationally, with dram_adx stable; when read_allowed=1 the FSM moves to R_WAIT.
REQ-028 R_WAIT -> on dram_rd_valid: the line is pushed into a 2-entry line buffer and the address advances. The next state is R_IDLE if all lines are fetched, R_FULL if the buffer holds 2 lines after the push, else R_ISSUE.
REQ-029 R_FULL -> R_ISSUE when a line is popped.
REQ-030 read_req SHALL be 0 outside R_ISSUE; dram_rd_valid outside R_WAIT SHALL be ignored.
REQ-031 sample_valid=1 whenever the line buffer is non-empty; sample_data = the head-line slice at the current offset, combinational from registered state.
REQ-032 sample_data SHALL hold stable while sample_valid=1 and sample_ready=0.
REQ-033 On sample_valid&sample_ready: the offset increments and the remaining count decrements. The head line is popped when the offset wraps past PACK_SIZE-1 or the final sample transfers.
REQ-034 Simultaneous push and pop SHALL both take effect in the same cycle, leaving the occupancy unchanged.
REQ-035 On the final transfer, done SHALL pulse on the next cycle and busy SHALL fall on that same cycle.

Reset
REQ-036 On resetn=0 at a clock edge, the following SHALL apply on the next cycle: busy=0, done=0, sample_valid=0, read_req=0, dram_adx=0, sample_data=0, FSM=R_IDLE, buffer empty, counters 0.
REQ-037 Reset mid-readout SHALL abort the readout. Read data returning after reset SHALL be ignored.

Verification
REQ-038 start_sample=0, sample_count=4, read_allowed=1, data returned 3 cycles later, sample_ready=1 -> one read at adx 0; emitted samples are line[31:0], [63:32], [95:64], [127:96]; done pulses once.
REQ-039 start_sample=6, sample_count=5 -> reads at adx 8 and 16; emits samples 6, 7, 8, 9, 10 (offsets 2, 3, 0, 1, 2 of those lines); exactly 2 reads issued.
REQ-040 sample_ready=0 for 20 cycles during a 12-sample readout -> at most 2 lines buffered with no read issued while in R_FULL; sample_data stable throughout; all 12 samples emitted in order after sample_ready=1.
REQ-041 read_allowed held 0 for 10 cycles in R_ISSUE -> read_req=0 throughout and dram_adx stable; the read is issued on the first cycle read_allowed=1.
REQ-042 resetn=0 while in R_WAIT, then dram_rd_valid=1 -> no sample_valid, busy=0; a new start then proceeds normally.
REQ-043 start with sample_count=0, and start asserted while busy -> done the next cycle with no read_req in the first case; the second start is ignored, so the first readout's addresses and samples are unchanged.
